// File: rtl/mux_operand_skid.sv
// N-way operand selector with a registered valid/ready output backed by a 2-entry skid buffer.
// Optional macro MUX_ERR_COUNT_EN adds an 8-bit saturating count of accepted out-of-range selects.
module mux_operand_skid #(
    parameter int WIDTH = 32,
    parameter int N_IN  = 4,
    parameter int SEL_W = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [N_IN*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]      in_sel,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [WIDTH-1:0]      out_data,
    output logic [SEL_W-1:0]      out_sel,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  sel_err
`ifdef MUX_ERR_COUNT_EN
    ,
    output logic [7:0]            err_count
`endif
);

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_TWO   = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   main_data_q, main_data_d;
    logic [SEL_W-1:0]   main_sel_q, main_sel_d;
    logic               main_err_q, main_err_d;
    logic [WIDTH-1:0]   skid_data_q, skid_data_d;
    logic [SEL_W-1:0]   skid_sel_q, skid_sel_d;
    logic               skid_err_q, skid_err_d;
    logic               in_ready_q, in_ready_d;

    logic [WIDTH-1:0]   new_data;
    logic               new_err;
    logic               in_xfer;
    logic               out_xfer;

    // Out-of-range selects yield a zero word rather than an undefined slice.
    function automatic logic [WIDTH-1:0] pick_word(input logic [N_IN*WIDTH-1:0] d,
                                                   input logic [SEL_W-1:0]      s);
        logic [WIDTH-1:0] w;
        w = '0;
        for (int k = 0; k < N_IN; k++) begin
            if (s == SEL_W'(k)) begin
                w = d[k*WIDTH +: WIDTH];
            end
        end
        return w;
    endfunction

    function automatic logic sel_out_of_range(input logic [SEL_W-1:0] s);
        logic bad;
        bad = 1'b1;
        for (int k = 0; k < N_IN; k++) begin
            if (s == SEL_W'(k)) begin
                bad = 1'b0;
            end
        end
        return bad;
    endfunction

    assign new_data = pick_word(in_data, in_sel);
    assign new_err  = sel_out_of_range(in_sel);
    assign in_xfer  = in_valid & in_ready_q;
    assign out_xfer = (state_q != S_EMPTY) & out_ready;

    always_comb begin
        state_d     = state_q;
        main_data_d = main_data_q;
        main_sel_d  = main_sel_q;
        main_err_d  = main_err_q;
        skid_data_d = skid_data_q;
        skid_sel_d  = skid_sel_q;
        skid_err_d  = skid_err_q;

        unique case (state_q)
            S_EMPTY: begin
                if (in_xfer) begin
                    main_data_d = new_data;
                    main_sel_d  = in_sel;
                    main_err_d  = new_err;
                    state_d     = S_ONE;
                end
            end
            S_ONE: begin
                if (in_xfer && out_xfer) begin
                    main_data_d = new_data;
                    main_sel_d  = in_sel;
                    main_err_d  = new_err;
                end else if (in_xfer) begin
                    skid_data_d = new_data;
                    skid_sel_d  = in_sel;
                    skid_err_d  = new_err;
                    state_d     = S_TWO;
                end else if (out_xfer) begin
                    state_d = S_EMPTY;
                end
            end
            S_TWO: begin
                if (out_xfer) begin
                    main_data_d = skid_data_q;
                    main_sel_d  = skid_sel_q;
                    main_err_d  = skid_err_q;
                    state_d     = S_ONE;
                end
            end
            default: begin
                state_d = S_EMPTY;
            end
        endcase

        // Registered so in_ready never depends combinationally on out_ready.
        in_ready_d = (state_d != S_TWO);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_EMPTY;
            main_data_q <= '0;
            main_sel_q  <= '0;
            main_err_q  <= 1'b0;
            skid_data_q <= '0;
            skid_sel_q  <= '0;
            skid_err_q  <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            main_data_q <= main_data_d;
            main_sel_q  <= main_sel_d;
            main_err_q  <= main_err_d;
            skid_data_q <= skid_data_d;
            skid_sel_q  <= skid_sel_d;
            skid_err_q  <= skid_err_d;
            in_ready_q  <= in_ready_d;
        end
    end

`ifdef MUX_ERR_COUNT_EN
    logic [7:0] err_cnt_q, err_cnt_d;

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (in_xfer && new_err && (err_cnt_q != 8'hFF)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_cnt_q <= 8'd0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err_count = err_cnt_q;
`endif

    assign in_ready  = in_ready_q;
    assign out_valid = (state_q != S_EMPTY);
    assign out_data  = main_data_q;
    assign out_sel   = main_sel_q;
    assign sel_err   = main_err_q;

endmodule

// File: tb/tb_mux_operand_skid.sv
// Scoreboard bench for mux_operand_skid: a 4-input instance for flow/order and a 3-input one for range errors.
module tb_mux_operand_skid;

    logic        clk;
    logic        reset;

    logic [127:0] in_data;
    logic [1:0]   in_sel;
    logic         in_valid;
    logic         in_ready;
    logic [31:0]  out_data;
    logic [1:0]   out_sel;
    logic         out_valid;
    logic         out_ready;
    logic         sel_err;

    logic [95:0]  in_data3;
    logic [1:0]   in_sel3;
    logic         in_valid3;
    logic         in_ready3;
    logic [31:0]  out_data3;
    logic [1:0]   out_sel3;
    logic         out_valid3;
    logic         out_ready3;
    logic         sel_err3;
`ifdef MUX_ERR_COUNT_EN
    logic [7:0]   err_count;
    logic [7:0]   err_count3;
`endif

    mux_operand_skid #(.WIDTH(32), .N_IN(4), .SEL_W(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sel_err   (sel_err)
`ifdef MUX_ERR_COUNT_EN
        ,
        .err_count (err_count)
`endif
    );

    mux_operand_skid #(.WIDTH(32), .N_IN(3), .SEL_W(2)) dut3 (
        .clk       (clk),
        .reset     (reset),
        .in_data   (in_data3),
        .in_sel    (in_sel3),
        .in_valid  (in_valid3),
        .in_ready  (in_ready3),
        .out_data  (out_data3),
        .out_sel   (out_sel3),
        .out_valid (out_valid3),
        .out_ready (out_ready3),
        .sel_err   (sel_err3)
`ifdef MUX_ERR_COUNT_EN
        ,
        .err_count (err_count3)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        err;
        logic [1:0]  sel;
        logic [31:0] data;
    } exp_t;

    exp_t sb[$];
    int   errs;
    int   checks;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Scoreboard push/pop at the decision point, then advance one clock and check stall stability.
    task automatic cycle();
        exp_t        e;
        logic        hold;
        logic [31:0] hd;
        logic [1:0]  hs;
        logic        he;
        if (in_valid && in_ready) begin
            e.data = in_data[int'(in_sel)*32 +: 32];
            e.sel  = in_sel;
            e.err  = 1'b0;
            sb.push_back(e);
        end
        if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
                chk("sb_extra_output", 64'(1), 64'(0));
            end else begin
                e = sb.pop_front();
                chk("sb_data", 64'(out_data), 64'(e.data));
                chk("sb_sel", 64'(out_sel), 64'(e.sel));
                chk("sb_err", 64'(sel_err), 64'(e.err));
            end
        end
        hold = out_valid && !out_ready;
        hd   = out_data;
        hs   = out_sel;
        he   = sel_err;
        @(posedge clk);
        #1;
        if (hold) begin
            chk("stall_valid", 64'(out_valid), 64'(1));
            chk("stall_data", 64'(out_data), 64'(hd));
            chk("stall_sel", 64'(out_sel), 64'(hs));
            chk("stall_err", 64'(sel_err), 64'(he));
        end
    endtask

    initial begin
        int n;
        errs       = 0;
        checks     = 0;
        reset      = 1'b1;
        in_data    = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
        in_sel     = 2'd0;
        in_valid   = 1'b0;
        out_ready  = 1'b0;
        in_data3   = {32'hCCCCCCCC, 32'hBBBBBBBB, 32'hAAAAAAAA};
        in_sel3    = 2'd0;
        in_valid3  = 1'b0;
        out_ready3 = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_in_ready", 64'(in_ready), 64'(1));
        chk("rst_out_data", 64'(out_data), 64'(0));
        chk("rst_out_sel", 64'(out_sel), 64'(0));
        chk("rst_sel_err", 64'(sel_err), 64'(0));
        reset = 1'b0;
        cycle();

        // Single word, sel=2
        in_sel    = 2'd2;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        cycle();
        in_valid = 1'b0;
        chk("t1_out_valid", 64'(out_valid), 64'(1));
        chk("t1_out_data", 64'(out_data), 64'h33333333);
        chk("t1_out_sel", 64'(out_sel), 64'(2));
        chk("t1_sel_err", 64'(sel_err), 64'(0));
        cycle();
        chk("t1_out_valid_after", 64'(out_valid), 64'(0));

        // Stalled consumer: fill main and skid, third word held off
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_sel    = 2'd0;
        cycle();
        chk("t2_in_ready_one", 64'(in_ready), 64'(1));
        in_sel = 2'd1;
        cycle();
        chk("t2_in_ready_full", 64'(in_ready), 64'(0));
        in_sel = 2'd3;
        cycle();
        chk("t2_in_ready_held", 64'(in_ready), 64'(0));
        chk("t2_head_data", 64'(out_data), 64'h11111111);
        out_ready = 1'b1;
        cycle();
        chk("t2_second_data", 64'(out_data), 64'h22222222);
        chk("t2_in_ready_back", 64'(in_ready), 64'(1));
        cycle();
        in_valid = 1'b0;
        chk("t2_third_data", 64'(out_data), 64'h44444444);
        cycle();
        chk("t2_drained", 64'(out_valid), 64'(0));

        // Streaming at full rate
        in_valid  = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            in_sel = 2'(i % 4);
            cycle();
            chk("t3_in_ready", 64'(in_ready), 64'(1));
            chk("t3_out_valid", 64'(out_valid), 64'(1));
            chk("t3_out_sel", 64'(out_sel), 64'(i % 4));
        end
        in_valid = 1'b0;
        cycle();
        chk("t3_sb_empty", 64'(sb.size()), 64'(0));

        // Out-of-range select on the 3-input instance
        in_valid3 = 1'b1;
        in_sel3   = 2'd3;
        cycle();
        chk("t4_valid", 64'(out_valid3), 64'(1));
        chk("t4_data_zero", 64'(out_data3), 64'(0));
        chk("t4_sel_err", 64'(sel_err3), 64'(1));
        chk("t4_out_sel", 64'(out_sel3), 64'(3));
`ifdef MUX_ERR_COUNT_EN
        chk("t4_err_count_1", 64'(err_count3), 64'(1));
`endif
        in_sel3 = 2'd1;
        cycle();
        chk("t4_inrange_data", 64'(out_data3), 64'hBBBBBBBB);
        chk("t4_inrange_err", 64'(sel_err3), 64'(0));
        in_sel3 = 2'd3;
        repeat (300) cycle();
        in_valid3 = 1'b0;
        cycle();
        chk("t4_last_err", 64'(sel_err3), 64'(1));
`ifdef MUX_ERR_COUNT_EN
        chk("t4_err_count_sat", 64'(err_count3), 64'(255));
        chk("t4_err_count_4in", 64'(err_count), 64'(0));
`endif

        // Reset while both entries are occupied
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_sel    = 2'd2;
        cycle();
        in_sel = 2'd3;
        cycle();
        in_valid = 1'b0;
        chk("t5_full_before_rst", 64'(in_ready), 64'(0));
        reset = 1'b1;
        #1;
        chk("t5_rst_out_valid", 64'(out_valid), 64'(0));
        chk("t5_rst_in_ready", 64'(in_ready), 64'(1));
        sb.delete();
        @(posedge clk);
        #1;
        reset     = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cycle();
            chk("t5_no_stale_output", 64'(out_valid), 64'(0));
        end

        // Random traffic against the scoreboard
        for (int i = 0; i < 10000; i++) begin
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 1));
            in_sel    = 2'($urandom_range(0, 3));
            in_data   = {$urandom(), $urandom(), $urandom(), $urandom()};
            cycle();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        n = 0;
        while ((out_valid || sb.size() != 0) && n < 10) begin
            cycle();
            n++;
        end
        chk("t6_drain_timeout", 64'(n < 10), 64'(1));
        chk("t6_sb_empty", 64'(sb.size()), 64'(0));

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/mux_operand_skid.md
Name: mux_operand_skid

Overview:
- Parametrised N-way operand selector for the ALU operand paths of the multicycle MIPS datapath.
- Selects one of N_IN WIDTH-bit sources and registers the result.
- Output side has a valid/ready handshake backed by a 2-entry skid buffer, so a stalled consumer never loses a selected operand.
- Selection latency is 1 cycle.
- The selected source index travels with the data for debug and forwarding checks.

Parameters:
- WIDTH, 32, data width of each source and of the output.
- N_IN, 4, number of sources; legal range 2..16.
- SEL_W, 2, select width; must satisfy 2**SEL_W >= N_IN.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_data  in  N_IN*WIDTH  packed sources; source k occupies bits [k*WIDTH +: WIDTH].
- in_sel  in  SEL_W  source index.
- in_valid  in  1  in_data/in_sel are valid this cycle.
- in_ready  out  1  block can accept this cycle.
- out_data  out  WIDTH  selected operand.
- out_sel  out  SEL_W  index that produced out_data.
- out_valid  out  1  out_data/out_sel are valid.
- out_ready  in  1  consumer accepts this cycle.
- sel_err  out  1  high while the current output word came from an out-of-range in_sel.

Behaviour:
- Reset (async assert, released synchronously to clk):
  - out_valid=0, out_data=0, out_sel=0, sel_err=0, in_ready=1.
  - Both buffer entries are cleared; state is EMPTY.
  - A reset asserted mid-transfer discards all buffered words. No handshake completes in the cycle reset is high.
- Selection:
  - sel_word = in_data[in_sel*WIDTH +: WIDTH] when in_sel < N_IN.
  - Otherwise sel_word = 0 and the error bit is set.
  - The error bit is stored with the word in whichever entry captures it.
- Transfers:
  - Input transfer = in_valid & in_ready. Output transfer = out_valid & out_ready.
  - in_ready = ~skid_full. It is a register output with no combinational path from out_ready.
  - out_data, out_sel and sel_err always reflect the main entry. out_valid = main_full.
- State machine (EMPTY, ONE, TWO):
  - EMPTY: on an input transfer, the word goes to main -> ONE.
  - ONE, input only: if out_ready=0, the word goes to skid -> TWO.
  - ONE, output only: -> EMPTY.
  - ONE, input and output in the same cycle: the new word replaces main -> ONE.
  - ONE, no transfer: hold.
  - TWO: in_ready=0. On an output transfer, skid moves to main -> ONE, and in_ready=1 next cycle. Otherwise hold.
- Latency: a word accepted in cycle t appears on out_* at t+1 when the buffer was EMPTY or draining.
- Ordering: strict FIFO order; no word is duplicated or dropped.
- Data stability: while out_valid=1 and out_ready=0, out_data, out_sel and sel_err must not change.
- in_data and in_sel are don't-care when in_valid=0.

Optional Feature:
- Macro: MUX_ERR_COUNT_EN.
- When defined:
  - Adds output port err_count (8 bits): a saturating count of accepted input transfers with out-of-range in_sel.
  - Counts on acceptance, not on output.
  - Resets to 0 and holds at 255.
- When undefined: the port and counter are absent. sel_err behaviour is unchanged.

Test Plan:
- Reset, then N_IN=4 and WIDTH=32 with sources 0x11111111, 0x22222222, 0x33333333, 0x44444444, in_sel=2, in_valid=1 for one cycle, out_ready=1.
  -> out_valid=1 next cycle, out_data=0x33333333, out_sel=2, sel_err=0; out_valid=0 the cycle after.
- out_ready=0, then push three words with sel=0, 1, 3.
  -> first two accepted; in_ready=0 after the second; third held off.
  -> raise out_ready: outputs appear in order 0x11111111, 0x22222222, then 0x44444444 after the third is accepted.
- Continuous in_valid=1 and out_ready=1 for 16 cycles with in_sel cycling 0..3.
  -> one output per cycle, 1-cycle latency, in_ready stays 1.
- N_IN=3, in_sel=3.
  -> out_data=0, sel_err=1, out_sel=3. With MUX_ERR_COUNT_EN: err_count=1; after 300 such transfers err_count=255.
- Buffer in state TWO, assert reset for one cycle mid-stall.
  -> out_valid=0, in_ready=1 immediately. Neither stalled word is ever emitted after reset release.
- Random in_valid/out_ready at 50% each over 10k cycles, compared against a scoreboard FIFO.
  -> no loss, duplication or reorder; outputs stable while stalled.
